// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, default widths and counter sizing for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DIV_DW_DEF = 16;
    localparam int DIV_VW_DEF = 8;

    function automatic int div_cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   r,
    input  logic          dvd_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   r_next,
    output logic          q_bit
);
    localparam int RW = VW + 1;

    logic [VW+1:0] r_sh;
    logic [VW+1:0] dvs_ext;

    // r is always below divisor, so its top bit is zero and the full-width shift equals {r[VW-1:0], bit}
    assign r_sh    = {r, dvd_bit};
    assign dvs_ext = {2'b00, divisor};
    assign q_bit   = (r_sh >= dvs_ext);
    assign r_next  = q_bit ? RW'(r_sh - dvs_ext) : r_sh[VW:0];

endmodule

// File: rtl/div_seq_param.sv
// rtl/div_seq_param.sv - multi-cycle radix-2 restoring divider with valid/ready handshakes
// Define DIV_SIGNED_EN to add the in_signed port and two's-complement operands.
module div_seq_param
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEF,
    parameter int VW = DIV_VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
`ifdef DIV_SIGNED_EN
    input  logic          in_signed,
`endif
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = div_cnt_w(DW);

    div_state_t    state_q, state_d;
    logic [DW-1:0] dvd_q, quo_q, dvd_mag, quo_fix;
    logic [VW-1:0] dvs_q, dvs_mag, rem_fix;
    logic [VW:0]   rem_q, step_r;
    logic [CW-1:0] cnt_q;
    logic          fin_q, dbz_q, step_q, accept, dvs_zero;
    logic          neg_quo_d, neg_rem_d, neg_quo_q, neg_rem_q;

    assign accept   = in_valid && in_ready;
    assign dvs_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
    assign neg_rem_d = in_signed & dividend[DW-1];
    assign neg_quo_d = neg_rem_d ^ (in_signed & divisor[VW-1]);
    assign dvd_mag   = neg_rem_d ? -dividend : dividend;
    assign dvs_mag   = (in_signed & divisor[VW-1]) ? -divisor : divisor;
`else
    assign neg_rem_d = 1'b0;
    assign neg_quo_d = 1'b0;
    assign dvd_mag   = dividend;
    assign dvs_mag   = divisor;
`endif

    // The most-negative dividend over -1 negates to itself, which is the required wrap
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];

    div_step #(.VW(VW)) u_step (
        .r       (rem_q),
        .dvd_bit (dvd_q[cnt_q]),
        .divisor (dvs_q),
        .r_next  (step_r),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = dvs_zero ? DONE : CALC;
            CALC:    if (fin_q) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // fin_q marks the extra CALC cycle whose edge enters DONE and applies the sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            dbz_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dvd_q     <= dvd_mag;
                        dvs_q     <= dvs_mag;
                        cnt_q     <= CW'(DW - 1);
                        fin_q     <= 1'b0;
                        neg_quo_q <= neg_quo_d;
                        neg_rem_q <= neg_rem_d;
                        dbz_q     <= dvs_zero;
                        quo_q     <= dvs_zero ? '1 : '0;
                        rem_q     <= dvs_zero ? {1'b0, dividend[VW-1:0]} : '0;
                    end
                end
                CALC: begin
                    if (!fin_q) begin
                        rem_q <= step_r;
                        quo_q <= {quo_q[DW-2:0], step_q};
                        if (cnt_q == '0) begin
                            fin_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end else begin
                        quo_q <= quo_fix;
                        rem_q <= {1'b0, rem_fix};
                        fin_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q[VW-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_param.sv
// tb/tb_div_seq_param.sv - scoreboard bench for div_seq_param (DW=16, VW=8); signed cases under DIV_SIGNED_EN
module tb_div_seq_param;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
`ifdef DIV_SIGNED_EN
    logic        in_signed;
`endif

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    div_seq_param #(.DW(16), .VW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
`ifdef DIV_SIGNED_EN
        .in_signed   (in_signed),
`endif
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    function automatic res_t model(input logic [15:0] a, input logic [7:0] b, input logic sg);
        res_t m;
        int   sa;
        int   sd;
        if (b == 8'd0) begin
            m.q   = 16'hFFFF;
            m.r   = a[7:0];
            m.dbz = 1'b1;
        end else if (sg) begin
            sa    = int'($signed(a));
            sd    = int'($signed(b));
            m.q   = 16'(sa / sd);
            m.r   = 8'(sa % sd);
            m.dbz = 1'b0;
        end else begin
            m.q   = a / {8'd0, b};
            m.r   = 8'(a % {8'd0, b});
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    // Edges are counted from operand presentation, so the accepting edge is edge 1.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic sg,
                          input int hold, input string name);
        res_t e;
        int   lat;
        int   exp_lat;
        exp_lat = (b == 8'd0) ? 1 : 18;
        exp_q.push_back(model(a, b, sg));
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        in_signed = sg;
`endif
        @(posedge clk); #1;
        lat = 1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: in_ready=%b required 0", name, in_ready);
        end
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: edges=%0d required %0d", name, lat, exp_lat);
        end
        e = exp_q.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            failures++;
            $display("FAIL %s result: q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                     name, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {2'b10, e.q, e.r, e.dbz}) begin
                failures++;
                $display("FAIL %s hold%0d: v=%b rdy=%b q=%h r=%h required v=1 rdy=0 q=%h r=%h",
                         name, i, out_valid, in_ready, quotient, remainder, e.q, e.r);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s consume: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef DIV_SIGNED_EN
        in_signed = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {2'b10, 16'h0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset: rdy=%b v=%b q=%h r=%h dbz=%b required 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_op(16'd1000, 8'd7, 1'b0, 0, "1000/7");
        run_op(16'hFFFF, 8'hFF, 1'b0, 0, "ffff/ff");
        run_op(16'd5, 8'd200, 1'b0, 0, "5/200");
        run_op(16'hFFFF, 8'd1, 1'b0, 0, "ffff/1");
        run_op(16'd0, 8'd13, 1'b0, 0, "0/13");
    endtask

    task automatic test_div_zero();
        run_op(16'h1234, 8'd0, 1'b0, 0, "1234/0");
    endtask

    task automatic test_backpressure();
        run_op(16'hBEEF, 8'h3C, 1'b0, 5, "backpressure");
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        exp_q.push_back(model(16'd1000, 8'd7, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {2'b10, 16'h0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid: rdy=%b v=%b q=%h r=%h dbz=%b required 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'd100, 8'd9, 1'b0, 0, "100/9 after reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = (i == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(a, b, 1'b0, 0, "b2b");
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        run_op(16'hFF9C, 8'h07, 1'b1, 0, "s -100/7");
        run_op(16'hFF9C, 8'h07, 1'b0, 0, "u ff9c/7");
        run_op(16'h8000, 8'hFF, 1'b1, 0, "s min/-1");
        run_op(16'h0064, 8'hF9, 1'b1, 0, "s 100/-7");
        run_op(16'hFF9C, 8'h00, 1'b1, 0, "s div0");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
